// File: rtl/spwm_carrier_deadtime_core.sv
// Three-phase sine PWM: ce divider, triangle carrier comparator and
// per-phase complementary gate drive with programmable deadtime.

module spwm_deadtime_phase #(
    parameter int DT_WIDTH = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_pwm,
    input  logic [DT_WIDTH-1:0] i_deadtime,
    output logic                o_h,
    output logic                o_l
);

    logic                r_prev;
    logic                r_h;
    logic                r_l;
    logic [DT_WIDTH-1:0] r_dcnt;

    // A zero deadtime also clears any running gap so the new side holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
            r_h    <= 1'b0;
            r_l    <= 1'b0;
            r_dcnt <= '0;
        end else if (i_pwm != r_prev) begin
            r_prev <= i_pwm;
            if (i_deadtime == '0) begin
                r_h    <= i_pwm;
                r_l    <= ~i_pwm;
                r_dcnt <= '0;
            end else begin
                r_h    <= 1'b0;
                r_l    <= 1'b0;
                r_dcnt <= i_deadtime - DT_WIDTH'(1);
            end
        end else if (r_dcnt != '0) begin
            r_dcnt <= r_dcnt - DT_WIDTH'(1);
            r_h    <= 1'b0;
            r_l    <= 1'b0;
        end else begin
            r_h <= r_prev;
            r_l <= ~r_prev;
        end
    end

    assign o_h = r_h;
    assign o_l = r_l;

endmodule

module spwm_carrier_deadtime_core #(
    parameter int DIV_WIDTH = 16,
    parameter int ACC_WIDTH = 32,
    parameter int SIN_WIDTH = 10,
    parameter int DT_WIDTH  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] divider,
    input  logic [ACC_WIDTH-1:0] tuning_word,
    input  logic [DT_WIDTH-1:0]  deadtime,
    input  logic [SIN_WIDTH-1:0] sinA,
    input  logic [SIN_WIDTH-1:0] sinB,
    input  logic [SIN_WIDTH-1:0] sinC,
    output logic                 ce_mod,
    output logic                 pwmA,
    output logic                 pwmB,
    output logic                 pwmC,
    output logic                 AH,
    output logic                 AL,
    output logic                 BH,
    output logic                 BL,
    output logic                 CH,
    output logic                 CL
);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic                 r_ce;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_pwm_a;
    logic                 r_pwm_b;
    logic                 r_pwm_c;
    logic [SIN_WIDTH-1:0] w_ramp;
    logic [SIN_WIDTH-1:0] w_carrier;

    // >= rather than == so a divider lowered below cnt fires immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_ce  <= 1'b0;
        end else if (r_cnt >= divider) begin
            r_cnt <= '0;
            r_ce  <= 1'b1;
        end else begin
            r_cnt <= r_cnt + DIV_WIDTH'(1);
            r_ce  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else begin
            r_acc <= r_acc + tuning_word;
        end
    end

    // Upper half of the phase folds back down to make the triangle.
    assign w_ramp    = r_acc[ACC_WIDTH-2 -: SIN_WIDTH];
    assign w_carrier = r_acc[ACC_WIDTH-1] ? ~w_ramp : w_ramp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_a <= 1'b0;
            r_pwm_b <= 1'b0;
            r_pwm_c <= 1'b0;
        end else begin
            r_pwm_a <= (sinA > w_carrier);
            r_pwm_b <= (sinB > w_carrier);
            r_pwm_c <= (sinC > w_carrier);
        end
    end

    spwm_deadtime_phase #(.DT_WIDTH(DT_WIDTH)) u_dt_a (
        .clk        (clk),
        .rst        (rst),
        .i_pwm      (r_pwm_a),
        .i_deadtime (deadtime),
        .o_h        (AH),
        .o_l        (AL)
    );

    spwm_deadtime_phase #(.DT_WIDTH(DT_WIDTH)) u_dt_b (
        .clk        (clk),
        .rst        (rst),
        .i_pwm      (r_pwm_b),
        .i_deadtime (deadtime),
        .o_h        (BH),
        .o_l        (BL)
    );

    spwm_deadtime_phase #(.DT_WIDTH(DT_WIDTH)) u_dt_c (
        .clk        (clk),
        .rst        (rst),
        .i_pwm      (r_pwm_c),
        .i_deadtime (deadtime),
        .o_h        (CH),
        .o_l        (CL)
    );

    assign ce_mod = r_ce;
    assign pwmA   = r_pwm_a;
    assign pwmB   = r_pwm_b;
    assign pwmC   = r_pwm_c;

endmodule

// File: tb/tb_spwm_carrier_deadtime_core.sv
// Randomised self-checking bench for spwm_carrier_deadtime_core against a
// timeline-based model of the divider, triangle carrier and deadtime gaps.

module tb_spwm_carrier_deadtime_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] divider = '0;
    logic [31:0] tuning_word = '0;
    logic [4:0]  deadtime = '0;
    logic [9:0]  sinA = '0;
    logic [9:0]  sinB = '0;
    logic [9:0]  sinC = '0;
    logic        ce_mod;
    logic        pwmA, pwmB, pwmC;
    logic        AH, AL, BH, BL, CH, CL;
    logic [2:0]  w_pwm;
    logic [2:0]  w_h;
    logic [2:0]  w_l;

    int n_cmp = 0;
    int n_err = 0;

    spwm_carrier_deadtime_core dut (
        .clk         (clk),
        .rst         (rst),
        .divider     (divider),
        .tuning_word (tuning_word),
        .deadtime    (deadtime),
        .sinA        (sinA),
        .sinB        (sinB),
        .sinC        (sinC),
        .ce_mod      (ce_mod),
        .pwmA        (pwmA),
        .pwmB        (pwmB),
        .pwmC        (pwmC),
        .AH          (AH),
        .AL          (AL),
        .BH          (BH),
        .BL          (BL),
        .CH          (CH),
        .CL          (CL)
    );

    always #5 clk = ~clk;

    assign w_pwm = {pwmC, pwmB, pwmA};
    assign w_h   = {CH, BH, AH};
    assign w_l   = {CL, BL, AL};

    // Reference model state: elapsed-count divider, phase as a plain integer,
    // and for each phase the edge index of its last pwm change.
    longint      m_acc = 0;
    longint      m_cnt = 0;
    logic        exp_ce = 1'b0;
    logic [2:0]  exp_pwm = '0;
    logic [2:0]  exp_h = '0;
    logic [2:0]  exp_l = '0;
    logic [2:0]  lvl = '0;
    int          chg [3] = '{-1000, -1000, -1000};
    int          gap [3] = '{0, 0, 0};
    int          edge_n = 0;

    task automatic tick();
        logic       r;
        longint     div;
        longint     tw;
        int         dt;
        int         s [3];
        int         p;
        int         car;
        logic [2:0] pin;
        logic [2:0] newp;
        r    = rst;
        div  = longint'(divider);
        tw   = longint'(tuning_word);
        dt   = int'(deadtime);
        s[0] = int'(sinA);
        s[1] = int'(sinB);
        s[2] = int'(sinC);
        pin  = exp_pwm;
        @(posedge clk);
        edge_n++;
        if (r) begin
            m_acc   = 0;
            m_cnt   = 0;
            exp_ce  = 1'b0;
            exp_pwm = '0;
            exp_h   = '0;
            exp_l   = '0;
            lvl     = '0;
            for (int k = 0; k < 3; k++) begin
                chg[k] = -1000;
                gap[k] = 0;
            end
        end else begin
            if (m_cnt >= div) begin
                m_cnt  = 0;
                exp_ce = 1'b1;
            end else begin
                m_cnt  = m_cnt + 1;
                exp_ce = 1'b0;
            end
            p   = int'(m_acc / 2097152);
            car = (p < 1024) ? p : 2047 - p;
            for (int k = 0; k < 3; k++) begin
                newp[k] = (s[k] > car);
                if (pin[k] !== lvl[k]) begin
                    lvl[k] = pin[k];
                    chg[k] = edge_n;
                    gap[k] = dt;
                end
                if (edge_n - chg[k] < gap[k]) begin
                    exp_h[k] = 1'b0;
                    exp_l[k] = 1'b0;
                end else begin
                    exp_h[k] = lvl[k];
                    exp_l[k] = ~lvl[k];
                end
            end
            exp_pwm = newp;
            m_acc   = (m_acc + tw) % 64'sd4294967296;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        divider     = 16'd3;
        tuning_word = 32'd12345;
        deadtime    = 5'd0;
        sinA = 10'd0;
        sinB = 10'd0;
        sinC = 10'd0;
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({ce_mod, w_pwm, w_h, w_l} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_state: got %b want 0",
                     {ce_mod, w_pwm, w_h, w_l});
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (w_l !== 3'b111 || w_h !== 3'b000) begin
            n_err++;
            $display("FAIL reset_release_low: H=%b L=%b want H=000 L=111",
                     w_h, w_l);
        end
    endtask

    task automatic test_divider();
        int pulses;
        tuning_word = '0;
        divider = 16'd3;
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            tick();
            n_cmp++;
            if (ce_mod !== ((i % 4) == 0)) begin
                n_err++;
                $display("FAIL div3_edge%0d: got %b want %b",
                         i, ce_mod, (i % 4) == 0);
            end
        end
        divider = 16'd0;
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_cmp++;
            if (ce_mod !== 1'b1) begin
                n_err++;
                $display("FAIL div0_edge%0d: got %b want 1", i, ce_mod);
            end
        end
        divider = 16'd1000;
        do_reset();
        pulses = 0;
        for (int i = 0; i < 500; i++) begin
            tick();
            pulses += int'(ce_mod);
        end
        n_cmp++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL div1000_early: got %0d pulses want 0", pulses);
        end
        divider = 16'd2;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (ce_mod !== (i == 0 || i == 3)) begin
                n_err++;
                $display("FAIL div_lowered_%0d: got %b want %b",
                         i, ce_mod, (i == 0 || i == 3));
            end
        end
    endtask

    task automatic test_static();
        divider     = 16'd5;
        tuning_word = '0;
        deadtime    = 5'd3;
        sinA = 10'd0;
        sinB = 10'd1;
        sinC = 10'd1023;
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        n_cmp++;
        if (w_pwm !== 3'b110) begin
            n_err++;
            $display("FAIL static_pwm: got %b want 110", w_pwm);
        end
        n_cmp++;
        if (w_h !== 3'b110 || w_l !== 3'b001) begin
            n_err++;
            $display("FAIL static_gates: H=%b L=%b want H=110 L=001",
                     w_h, w_l);
        end
    endtask

    task automatic test_triangle();
        int want [3] = '{1024, 0, 2046};
        int sv   [3] = '{512, 0, 1023};
        int hi;
        tuning_word = 32'h0020_0000;
        deadtime    = 5'd2;
        sinB = 10'd300;
        sinC = 10'd700;
        sinA = 10'd512;
        do_reset();
        for (int t = 0; t < 3; t++) begin
            sinA = 10'(sv[t]);
            hi = 0;
            for (int i = 0; i < 2048; i++) begin
                tick();
                hi += int'(pwmA);
                n_cmp++;
                if (w_pwm !== exp_pwm) begin
                    n_err++;
                    $display("FAIL tri_pwm_t%0d_c%0d: got %b want %b",
                             t, i, w_pwm, exp_pwm);
                end
            end
            n_cmp++;
            if (hi != want[t]) begin
                n_err++;
                $display("FAIL tri_duty_sin%0d: got %0d want %0d",
                         sv[t], hi, want[t]);
            end
        end
    endtask

    task automatic test_deadtime();
        tuning_word = '0;
        deadtime = 5'd5;
        sinA = 10'd0;
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        sinA = 10'd1023;
        tick();
        n_cmp++;
        if (pwmA !== 1'b1 || AL !== 1'b1 || AH !== 1'b0) begin
            n_err++;
            $display("FAIL dt5_pre: pwm=%b AH=%b AL=%b want 1 0 1",
                     pwmA, AH, AL);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (AH !== 1'b0 || AL !== 1'b0) begin
                n_err++;
                $display("FAIL dt5_gap%0d: AH=%b AL=%b want 0 0",
                         i, AH, AL);
            end
        end
        tick();
        n_cmp++;
        if (AH !== 1'b1 || AL !== 1'b0) begin
            n_err++;
            $display("FAIL dt5_after: AH=%b AL=%b want 1 0", AH, AL);
        end
        deadtime = 5'd0;
        sinA = 10'd0;
        tick();
        tick();
        n_cmp++;
        if (AH !== 1'b0 || AL !== 1'b1) begin
            n_err++;
            $display("FAIL dt0_fall: AH=%b AL=%b want 0 1", AH, AL);
        end
        sinA = 10'd1023;
        tick();
        tick();
        n_cmp++;
        if (AH !== 1'b1 || AL !== 1'b0) begin
            n_err++;
            $display("FAIL dt0_rise: AH=%b AL=%b want 1 0", AH, AL);
        end
    endtask

    task automatic test_glitch();
        tuning_word = '0;
        deadtime = 5'd10;
        sinA = 10'd0;
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        sinA = 10'd1023;
        tick();
        sinA = 10'd0;
        tick();
        tick();
        deadtime = 5'd2;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            n_cmp++;
            if (AH !== 1'b0 || AL !== 1'b0) begin
                n_err++;
                $display("FAIL glitch_gap%0d: AH=%b AL=%b want 0 0",
                         i, AH, AL);
            end
        end
        tick();
        n_cmp++;
        if (AH !== 1'b0 || AL !== 1'b1) begin
            n_err++;
            $display("FAIL glitch_after: AH=%b AL=%b want 0 1", AH, AL);
        end
    endtask

    task automatic test_reset_midrun();
        divider     = 16'd0;
        tuning_word = 32'h0123_4567;
        deadtime    = 5'd0;
        sinA = 10'd1023;
        sinB = 10'd900;
        sinC = 10'd600;
        for (int i = 0; i < 40; i++) tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({ce_mod, w_pwm, w_h, w_l} !== 10'd0) begin
            n_err++;
            $display("FAIL midrun_reset: got %b want 0",
                     {ce_mod, w_pwm, w_h, w_l});
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (w_l !== 3'b111 || w_h !== 3'b000) begin
            n_err++;
            $display("FAIL midrun_release: H=%b L=%b want H=000 L=111",
                     w_h, w_l);
        end
        for (int i = 0; i < 50; i++) begin
            tick();
            n_cmp++;
            if (w_pwm !== exp_pwm) begin
                n_err++;
                $display("FAIL midrun_pwm%0d: got %b want %b",
                         i, w_pwm, exp_pwm);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 20000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 199) == 0)
                divider = 16'($urandom_range(0, 7));
            if ($urandom_range(0, 299) == 0) begin
                case ($urandom_range(0, 3))
                    0: tuning_word = 32'd0;
                    1: tuning_word = 32'h0020_0000;
                    2: tuning_word = 32'h0100_0000;
                    default: tuning_word = $urandom;
                endcase
            end
            if ($urandom_range(0, 49) == 0)
                deadtime = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) sinA = 10'($urandom);
            if ($urandom_range(0, 3) == 0) sinB = 10'($urandom);
            if ($urandom_range(0, 3) == 0) sinC = 10'($urandom);
            tick();
            n_cmp++;
            if (ce_mod !== exp_ce) begin
                n_err++;
                $display("FAIL rnd_ce%0d: got %b want %b", i, ce_mod, exp_ce);
            end
            n_cmp++;
            if (w_pwm !== exp_pwm) begin
                n_err++;
                $display("FAIL rnd_pwm%0d: got %b want %b",
                         i, w_pwm, exp_pwm);
            end
            n_cmp++;
            if (w_h !== exp_h) begin
                n_err++;
                $display("FAIL rnd_h%0d: got %b want %b", i, w_h, exp_h);
            end
            n_cmp++;
            if (w_l !== exp_l) begin
                n_err++;
                $display("FAIL rnd_l%0d: got %b want %b", i, w_l, exp_l);
            end
            n_cmp++;
            if ((w_h & w_l) !== 3'b000) begin
                n_err++;
                $display("FAIL rnd_overlap%0d: H&L=%b want 000",
                         i, w_h & w_l);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_divider();
        test_static();
        test_triangle();
        test_deadtime();
        test_glitch();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
